// File: rtl/mux_scan_capture_pkg.sv
// Shared definitions for the scanned 4:1 mux capture stage.
// Optional feature macro: MUX_SCAN_PARITY_EN (parity helper used only when defined).
package mux_scan_capture_pkg;

  localparam int unsigned SEL_W = 2;
  localparam logic [SEL_W-1:0] LAST_CH = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } scan_state_t;

  function automatic logic word_parity_of(input logic [3:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// Loadable 4-bit settle down-counter; done flags the last settle cycle (count==1).
module mux_scan_settle_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] count;

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd1);

endmodule

// File: rtl/mux_scan_capture.sv
// Scan sequencer around the 4:1 lab mux: steps sel through all channels,
// settles, samples x_in and presents the 4-bit word with valid/ready.
// Optional feature macro: MUX_SCAN_PARITY_EN adds the word_parity output.
module mux_scan_capture
  import mux_scan_capture_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_CH        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             x_in,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [3:0]       word_out,
  output logic             word_valid,
  input  logic             word_ready,
`ifdef MUX_SCAN_PARITY_EN
  output logic             word_parity,
`endif
  output logic             overrun
);

  localparam logic [3:0]  SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam scan_state_t FIRST_ST  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  scan_state_t           state;
  logic [NUM_CH-2:0]     shadow;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_done;

  // Counter reloads whenever a new settle window opens.
  always_comb begin
    cnt_load = 1'b0;
    unique case (state)
      IDLE:    cnt_load = start;
      SAMPLE:  cnt_load = (sel != LAST_CH);
      HOLD:    cnt_load = word_ready && start;
      default: cnt_load = 1'b0;
    endcase
    cnt_dec = (state == SETTLE);
  end

  mux_scan_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_LD),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  // Scan FSM, shadow capture, word assembly and overrun flag.
  // Shadow is a right-shift register filled MSB-first, so after channels
  // 0..2 it holds {x2,x1,x0}, the same layout as indexing shadow[sel].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= '0;
      busy        <= 1'b0;
      word_out    <= '0;
      word_valid  <= 1'b0;
      overrun     <= 1'b0;
      shadow      <= '0;
`ifdef MUX_SCAN_PARITY_EN
      word_parity <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sel   <= '0;
            busy  <= 1'b1;
            state <= FIRST_ST;
          end
        end
        SETTLE: begin
          if (start) overrun <= 1'b1;
          if (cnt_done) state <= SAMPLE;
        end
        SAMPLE: begin
          if (start) overrun <= 1'b1;
          if (sel != LAST_CH) begin
            shadow <= {x_in, shadow[NUM_CH-2:1]};
            sel    <= sel + 1'b1;
            state  <= FIRST_ST;
          end else begin
            word_out    <= {x_in, shadow};
`ifdef MUX_SCAN_PARITY_EN
            word_parity <= word_parity_of({x_in, shadow});
`endif
            word_valid  <= 1'b1;
            busy        <= 1'b0;
            sel         <= '0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            if (start) begin
              sel   <= '0;
              busy  <= 1'b1;
              state <= FIRST_ST;
            end else begin
              state <= IDLE;
            end
          end else if (start) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_capture.sv
// Self-checking bench for mux_scan_capture (SETTLE_CYCLES=2).
// Honours MUX_SCAN_PARITY_EN when defined for both bench and design.
module tb_mux_scan_capture;

  localparam int unsigned S      = 2;
  localparam int unsigned PERIOD = S + 1;
  localparam int unsigned LAT    = 4 * PERIOD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       word_ready = 1'b0;
  logic [3:0] chan = 4'b0000;
  logic       x_in;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] word_out;
  logic       word_valid;
  logic       overrun;
`ifdef MUX_SCAN_PARITY_EN
  logic       word_parity;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [3:0] last_word = 4'b0000;
  logic       exp_ovr   = 1'b0;

  // Lab mux: chan = {D,C,B,A}, sel = {a,b}
  assign x_in = chan[sel];

  always #5 clk = ~clk;

  mux_scan_capture #(.SETTLE_CYCLES(S), .NUM_CH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x_in       (x_in),
    .sel        (sel),
    .busy       (busy),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
`ifdef MUX_SCAN_PARITY_EN
    .word_parity(word_parity),
`endif
    .overrun    (overrun)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_sel"}, 8'(sel), 8'd0);
    check({tag, "_busy"}, 8'(busy), 8'd0);
    check({tag, "_word"}, 8'(word_out), 8'd0);
    check({tag, "_valid"}, 8'(word_valid), 8'd0);
    check({tag, "_ovr"}, 8'(overrun), 8'd0);
`ifdef MUX_SCAN_PARITY_EN
    check({tag, "_par"}, 8'(word_parity), 8'd0);
`endif
  endtask

  // Called right after the start edge; follows the scan to word_valid.
  task automatic follow_scan(input logic [3:0] c, input bit poke);
    logic [3:0] mask;
    int unsigned es;
    for (int j = 0; j <= int'(LAT); j++) begin
      if (j > 0) tick();
      if (poke && j == 5) begin
        start   = 1'b0;
        exp_ovr = 1'b1;
      end
      es = (j < int'(LAT)) ? (unsigned'(j) / PERIOD) : 0;
      check($sformatf("scan_j%0d_sel", j), 8'(sel), 8'(es));
      check($sformatf("scan_j%0d_busy", j), 8'(busy), 8'(j < int'(LAT)));
      check($sformatf("scan_j%0d_valid", j), 8'(word_valid), 8'(j == int'(LAT)));
      check($sformatf("scan_j%0d_ovr", j), 8'(overrun), 8'(exp_ovr));
      if (j < int'(LAT)) begin
        check($sformatf("scan_j%0d_keep", j), 8'(word_out), 8'(last_word));
        // only the channel being selected must carry the intended value
        mask = 4'b0001 << es;
        chan = (4'($urandom) & ~mask) | (c & mask);
      end else begin
        last_word = c;
        check("scan_word", 8'(word_out), 8'(c));
`ifdef MUX_SCAN_PARITY_EN
        check("scan_parity", 8'(word_parity), 8'(^c));
`endif
      end
      if (poke && j == 4) start = 1'b1;
    end
  endtask

  task automatic launch(input logic [3:0] c, input bit poke);
    chan  = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    follow_scan(c, poke);
  endtask

  // Hold n cycles under backpressure, then complete the handshake.
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      chan = 4'($urandom);
      tick();
      check($sformatf("hold%0d_valid", i), 8'(word_valid), 8'd1);
      check($sformatf("hold%0d_word", i), 8'(word_out), 8'(last_word));
      check($sformatf("hold%0d_busy", i), 8'(busy), 8'd0);
    end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check("drain_valid", 8'(word_valid), 8'd0);
    check("drain_word", 8'(word_out), 8'(last_word));
`ifdef MUX_SCAN_PARITY_EN
    check("drain_parity", 8'(word_parity), 8'(^last_word));
`endif
    check("drain_ovr", 8'(overrun), 8'(exp_ovr));
  endtask

  initial begin
    logic [3:0] c;

    // Reset held 3 cycles, then idle with no start
    rst_n = 1'b0;
    #1;
    check_cleared("rst_async");
    repeat (3) tick();
    check_cleared("rst_held");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("idle%0d_sel", i), 8'(sel), 8'd0);
      check($sformatf("idle%0d_busy", i), 8'(busy), 8'd0);
      check($sformatf("idle%0d_valid", i), 8'(word_valid), 8'd0);
    end

    // word_ready with nothing valid
    word_ready = 1'b1;
    repeat (3) tick();
    word_ready = 1'b0;
    check("ready_idle_valid", 8'(word_valid), 8'd0);
    check("ready_idle_busy", 8'(busy), 8'd0);

    // Single scan A=1 B=0 C=1 D=1 with 10 cycles of backpressure
    launch(4'b1101, 1'b0);
    drain(10);

    // Random scans with random backpressure
    for (int n = 0; n < 6; n++) begin
      launch(4'($urandom), 1'b0);
      drain(int'($urandom_range(0, 4)));
    end

    // Back-to-back: start held with the handshake
    launch(4'($urandom), 1'b0);
    repeat (2) tick();
    c = 4'($urandom);
    chan = c;
    word_ready = 1'b1;
    start = 1'b1;
    tick();
    word_ready = 1'b0;
    start = 1'b0;
    follow_scan(c, 1'b0);
    drain(0);
    check("b2b_no_ovr", 8'(overrun), 8'd0);

    // Overrun: start pulsed at k+5; word unaffected, flag sticky
    launch(4'b1101, 1'b1);
    drain(1);
    for (int n = 0; n < 2; n++) begin
      launch(4'($urandom), 1'b0);
      drain(0);
    end
    check("ovr_sticky", 8'(overrun), 8'd1);

    // Async reset mid-scan while sel==2
    chan = 4'b1101;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2 * PERIOD) tick();
    check("mid_sel2", 8'(sel), 8'd2);
    #2;
    rst_n = 1'b0;
    exp_ovr = 1'b0;
    #1;
    check_cleared("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check_cleared("mid_post");
    last_word = 4'b0000;
    launch(4'b0010, 1'b0);
    drain(0);
    launch(4'b0011, 1'b0);
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    mismatched++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "timeout");
  end

endmodule
